// File: rtl/univ_shift_pkg.sv
// -----------------------------------------------------------------------------
// univ_shift_pkg
// Shared definitions for the universal shift register and its burst controller.
//   - MODE_* : encodings of the 2-bit mode input
//   - cmd_t  : effective register command (same encoding as mode)
//   - state_t: burst controller state encoding
//   - cnt_width(): width of the burst down-counter for a given register width
// -----------------------------------------------------------------------------
package univ_shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Command applied to the data register on the next rising edge.
    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_SHR  = 2'b01,
        CMD_SHL  = 2'b10,
        CMD_LOAD = 2'b11
    } cmd_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter width able to hold WIDTH-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage : univ_shift_pkg

// File: rtl/shift_burst_ctrl.sv
// -----------------------------------------------------------------------------
// shift_burst_ctrl
// Burst sequencer: turns a start strobe into WIDTH consecutive shifts in the
// direction given by mode on the start edge, and otherwise passes mode through
// as the register command.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : burst request, honoured only in IDLE with a shift mode
//   mode         : requested register mode
//   shift_cmd_c  : effective command for the data register (combinational,
//                  derived from registered state and the mode input)
//   busy         : registered, high while in SHIFT
//   done         : registered, one-cycle pulse after the last burst shift
// -----------------------------------------------------------------------------
module shift_burst_ctrl
    import univ_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    output cmd_t       shift_cmd_c,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               dir_left;
    logic               start_ok;

    // A burst may only begin on a shift mode while idle.
    assign start_ok = start && ((mode == MODE_SHR) || (mode == MODE_SHL));

    // In SHIFT the latched direction wins; in IDLE the live mode drives the
    // register, which also makes the start edge perform the first shift.
    always_comb begin
        shift_cmd_c = cmd_t'(mode);
        if (state == ST_SHIFT) begin
            shift_cmd_c = dir_left ? CMD_SHL : CMD_SHR;
        end
    end

    // Burst FSM with down-counter and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            dir_left <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state    <= ST_SHIFT;
                        dir_left <= (mode == MODE_SHL);
                        count    <= CNT_W'(WIDTH - 1);
                        busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    count <= count - CNT_W'(1);
                    // Count reaching zero marks the WIDTH-th shift.
                    if (count == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : shift_burst_ctrl

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// WIDTH-bit universal register: hold, shift right, shift left, parallel load,
// plus an automatic serial burst that shifts the whole word out on one start.
// Optional build macro SHIFT_ROTATE_EN adds a rotate input that feeds the
// outgoing bit back in instead of ser_in.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   mode      : 00 hold, 01 shift right, 10 shift left, 11 load
//   d         : parallel load data
//   ser_in    : serial input bit for shifts
//   start     : burst request
//   rotate    : (SHIFT_ROTATE_EN only) recirculate the shifted-out bit
//   q, q_b    : register contents and its inverse
//   sout_lsb  : q[0]
//   sout_msb  : q[WIDTH-1]
//   busy      : burst in progress
//   done      : one-cycle pulse after a completed burst
// -----------------------------------------------------------------------------
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int unsigned           WIDTH   = 8,
    parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             start,
`ifdef SHIFT_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_b,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
);

    cmd_t shift_cmd_c;
    logic ins_right_c;
    logic ins_left_c;

    shift_burst_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .shift_cmd_c (shift_cmd_c),
        .busy        (busy),
        .done        (done)
    );

    // Bit entering the register on a right or left shift.
`ifdef SHIFT_ROTATE_EN
    assign ins_right_c = rotate ? q[0]       : ser_in;
    assign ins_left_c  = rotate ? q[WIDTH-1] : ser_in;
`else
    assign ins_right_c = ser_in;
    assign ins_left_c  = ser_in;
`endif

    // Data register and shift/load mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            case (shift_cmd_c)
                CMD_SHR:  q <= {ins_right_c, q[WIDTH-1:1]};
                CMD_SHL:  q <= {q[WIDTH-2:0], ins_left_c};
                CMD_LOAD: q <= d;
                default:  q <= q;
            endcase
        end
    end

    // Complementary and serial outputs are pure functions of the register.
    assign q_b      = ~q;
    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// Directed vectors for univ_shift_reg (WIDTH=8, RST_VAL=0). The driver applies
// one vector per clock and queues the hand-computed register state expected
// after that edge; an independent monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int unsigned W = 8;

    typedef struct {
        string          name;
        logic [W-1:0]   q;
        logic           busy;
        logic           done;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         ser_in;
    logic         start;
`ifdef SHIFT_ROTATE_EN
    logic         rotate;
`endif
    logic [W-1:0] q;
    logic [W-1:0] q_b;
    logic         sout_lsb;
    logic         sout_msb;
    logic         busy;
    logic         done;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Expected register contents of the three bursts, one entry per edge.
    logic [W-1:0] burst_r0[8] = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
    logic [W-1:0] burst_l1[8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    logic [W-1:0] burst_rot[8] = '{8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B};

    univ_shift_reg #(
        .WIDTH   (W),
        .RST_VAL ({W{1'b0}})
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .d        (d),
        .ser_in   (ser_in),
        .start    (start),
`ifdef SHIFT_ROTATE_EN
        .rotate   (rotate),
`endif
        .q        (q),
        .q_b      (q_b),
        .sout_lsb (sout_lsb),
        .sout_msb (sout_msb),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector across one rising edge and queue the expected result.
    task automatic step(input string nm, input logic r, input logic [1:0] m,
                        input logic [W-1:0] dv, input logic s, input logic st,
                        input logic [W-1:0] eq, input logic eb, input logic ed);
        exp_t e;
        rst    = r;
        mode   = m;
        d      = dv;
        ser_in = s;
        start  = st;
        @(posedge clk);
        e.name = nm;
        e.q    = eq;
        e.busy = eb;
        e.done = ed;
        sb.push_back(e);
        #2;
    endtask

    // Monitor: every edge the DUT presents a new register state.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (q !== e.q) begin
                    miscompares++;
                    $display("FAIL %s q: got %h expected %h", e.name, q, e.q);
                end
                if (q_b !== ~e.q) begin
                    miscompares++;
                    $display("FAIL %s q_b: got %h expected %h", e.name, q_b, ~e.q);
                end
                if (sout_lsb !== e.q[0]) begin
                    miscompares++;
                    $display("FAIL %s sout_lsb: got %b expected %b", e.name, sout_lsb, e.q[0]);
                end
                if (sout_msb !== e.q[W-1]) begin
                    miscompares++;
                    $display("FAIL %s sout_msb: got %b expected %b", e.name, sout_msb, e.q[W-1]);
                end
                if (busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL %s busy: got %b expected %b", e.name, busy, e.busy);
                end
                if (done !== e.done) begin
                    miscompares++;
                    $display("FAIL %s done: got %b expected %b", e.name, done, e.done);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        rst    = 1'b1;
        mode   = 2'b00;
        d      = '0;
        ser_in = 1'b0;
        start  = 1'b0;
`ifdef SHIFT_ROTATE_EN
        rotate = 1'b0;
`endif
        #2;

        // Reset dominates a load with start asserted.
        step("reset0", 1'b1, 2'b11, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("reset1", 1'b1, 2'b11, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Load then hold.
        step("load_a5", 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("hold", 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);

        // Manual shifts.
        step("shr_0", 1'b0, 2'b01, 8'h00, 1'b0, 1'b0, 8'h52, 1'b0, 1'b0);
        step("shl_1", 1'b0, 2'b10, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);

        // Right burst from A5 with ser_in=0; a second start with load mode
        // mid-burst must be ignored.
        for (int i = 0; i < 8; i++) begin
            if (i == 0)
                step("burst_r", 1'b0, 2'b01, 8'h00, 1'b0, 1'b1, burst_r0[i], 1'b1, 1'b0);
            else if (i == 3)
                step("burst_r_restart", 1'b0, 2'b11, 8'hFF, 1'b0, 1'b1, burst_r0[i], 1'b1, 1'b0);
            else
                step("burst_r", 1'b0, 2'b00, 8'hFF, 1'b0, 1'b0, burst_r0[i], (i < 7), (i == 7));
        end

        // New left burst accepted in the done cycle, ser_in=1.
        for (int i = 0; i < 8; i++)
            step("burst_l", 1'b0, (i == 0) ? 2'b10 : 2'b00, 8'h00, 1'b1, (i == 0),
                 burst_l1[i], (i < 7), (i == 7));
        step("after_burst", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

        // Start with hold/load modes is ignored.
        step("start_load", 1'b0, 2'b11, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
        step("start_hold", 1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);

        // Burst from FF aborted by reset after the third shift.
        step("load_ff", 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        step("abort_s1", 1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0);
        step("abort_s2", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h3F, 1'b1, 1'b0);
        step("abort_s3", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h1F, 1'b1, 1'b0);
        step("abort_rst", 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step("abort_quiet", 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("load_3c", 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);

`ifdef SHIFT_ROTATE_EN
        // Rotation: ser_in held at the opposite value to prove it is ignored.
        step("rot_load", 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        rotate = 1'b1;
        step("rot_shl", 1'b0, 2'b10, 8'h00, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step("rot_burst", 1'b0, (i == 0) ? 2'b01 : 2'b00, 8'h00, 1'b0, (i == 0),
                 burst_rot[i], (i < 7), (i == 7));
        step("rot_after", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
        rotate = 1'b0;
`endif

        // Let the monitor drain, bounded.
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_univ_shift_reg
